morse_message_sequencer: RTL and testbench

//  Buffers an ASCII message and feeds Morse_to_Signal one character at a time.
//  - Encodes A-Z/a-z/0-9 into pattern/length and pulses o_Start.
//  - Waits for the character to finish, then inserts the inter-character and inter-word gaps.
//  - Sits between the text source (UART/ROM) and Morse_to_Signal; sole owner of its i_Start.

---
 rtl/morse_message_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_morse_message_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_message_sequencer.sv
// Buffers ASCII characters in a small FIFO and hands them one at a time, Morse-encoded,
// to a Morse_to_Signal symbol generator, inserting inter-character and inter-word gaps.
module morse_message_sequencer #(
  parameter int unsigned UNIT_CYCLES    = 50_000_000,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS = 7
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Char_Valid,
  input  logic [7:0] i_Char,
  output logic       o_Char_Ready,
  input  logic       i_Abort,
  output logic       o_Start,
  output logic [4:0] o_Morse_Pattern,
  output logic [2:0] o_Morse_Length,
  input  logic       i_Done,
  output logic       o_Busy,
  output logic       o_Err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CntW      = $clog2(WORD_GAP_UNITS * UNIT_CYCLES + 1);
  localparam int unsigned WordExtra = (WORD_GAP_UNITS - CHAR_GAP_UNITS) * UNIT_CYCLES;

  localparam logic [CntW-1:0] CharGapLoad = CntW'(CHAR_GAP_UNITS * UNIT_CYCLES);
  // The FETCH cycle that pops a space counts as the first cycle of its word-gap extension.
  localparam logic [CntW-1:0] WordGapLoad = CntW'(WordExtra - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);
  localparam logic [AW:0]     PtrOne      = (AW + 1)'(1);

  typedef enum logic [2:0] {StIdle, StFetch, StStart, StWaitDone, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            start_q, err_q, done_q, abort_q;
  logic [4:0]      pattern_q;
  logic [2:0]      length_q;

  // Character FIFO
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d, empty_q, empty_d;
  logic        push, pop;
  logic [7:0]  fifo_head;

  assign push      = i_Char_Valid && !full_q && !i_Abort;
  assign pop       = (state_q == StFetch) && !empty_q && !i_Abort;
  assign fifo_head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_Abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_Char;
  end

  // Encoder: bit i of the pattern is symbol i, 1 = dash
  logic [7:0] up_char;
  logic       enc_valid, is_space;
  logic [4:0] enc_pat;
  logic [2:0] enc_len;

  assign is_space = (fifo_head == 8'h20);

  always_comb begin
    up_char = fifo_head;
    if (fifo_head >= "a" && fifo_head <= "z") up_char = fifo_head - 8'h20;
    enc_valid = 1'b1;
    enc_pat   = '0;
    enc_len   = '0;
    case (up_char)
      "A": {enc_pat, enc_len} = {5'b00010, 3'd2};
      "B": {enc_pat, enc_len} = {5'b00001, 3'd4};
      "C": {enc_pat, enc_len} = {5'b00101, 3'd4};
      "D": {enc_pat, enc_len} = {5'b00001, 3'd3};
      "E": {enc_pat, enc_len} = {5'b00000, 3'd1};
      "F": {enc_pat, enc_len} = {5'b00100, 3'd4};
      "G": {enc_pat, enc_len} = {5'b00011, 3'd3};
      "H": {enc_pat, enc_len} = {5'b00000, 3'd4};
      "I": {enc_pat, enc_len} = {5'b00000, 3'd2};
      "J": {enc_pat, enc_len} = {5'b01110, 3'd4};
      "K": {enc_pat, enc_len} = {5'b00101, 3'd3};
      "L": {enc_pat, enc_len} = {5'b00010, 3'd4};
      "M": {enc_pat, enc_len} = {5'b00011, 3'd2};
      "N": {enc_pat, enc_len} = {5'b00001, 3'd2};
      "O": {enc_pat, enc_len} = {5'b00111, 3'd3};
      "P": {enc_pat, enc_len} = {5'b00110, 3'd4};
      "Q": {enc_pat, enc_len} = {5'b01011, 3'd4};
      "R": {enc_pat, enc_len} = {5'b00010, 3'd3};
      "S": {enc_pat, enc_len} = {5'b00000, 3'd3};
      "T": {enc_pat, enc_len} = {5'b00001, 3'd1};
      "U": {enc_pat, enc_len} = {5'b00100, 3'd3};
      "V": {enc_pat, enc_len} = {5'b01000, 3'd4};
      "W": {enc_pat, enc_len} = {5'b00110, 3'd3};
      "X": {enc_pat, enc_len} = {5'b01001, 3'd4};
      "Y": {enc_pat, enc_len} = {5'b01101, 3'd4};
      "Z": {enc_pat, enc_len} = {5'b00011, 3'd4};
      "0": {enc_pat, enc_len} = {5'b11111, 3'd5};
      "1": {enc_pat, enc_len} = {5'b11110, 3'd5};
      "2": {enc_pat, enc_len} = {5'b11100, 3'd5};
      "3": {enc_pat, enc_len} = {5'b11000, 3'd5};
      "4": {enc_pat, enc_len} = {5'b10000, 3'd5};
      "5": {enc_pat, enc_len} = {5'b00000, 3'd5};
      "6": {enc_pat, enc_len} = {5'b00001, 3'd5};
      "7": {enc_pat, enc_len} = {5'b00011, 3'd5};
      "8": {enc_pat, enc_len} = {5'b00111, 3'd5};
      "9": {enc_pat, enc_len} = {5'b01111, 3'd5};
      default: enc_valid = 1'b0;
    endcase
  end

  logic done_rise;
  assign done_rise = i_Done && !done_q;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      pattern_q <= '0;
      length_q  <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= i_Done;
      case (state_q)
        StIdle: begin
          if (!empty_q && !i_Abort) state_q <= StFetch;
        end
        StFetch: begin
          if (i_Abort) begin
            state_q <= StIdle;
          end else if (enc_valid) begin
            pattern_q <= enc_pat;
            length_q  <= enc_len;
            start_q   <= 1'b1;
            state_q   <= StStart;
          end else if (is_space) begin
            if (WordExtra > 1) begin
              cnt_q   <= WordGapLoad;
              state_q <= StGap;
            end else begin
              state_q <= empty_d ? StIdle : StFetch;
            end
          end else begin
            err_q   <= 1'b1;
            state_q <= empty_d ? StIdle : StFetch;
          end
        end
        StStart: begin
          if (i_Abort) abort_q <= 1'b1;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          // An abort here is remembered so the symbol finishes but no gap follows.
          if (done_rise) begin
            abort_q <= 1'b0;
            if (abort_q || i_Abort) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= CharGapLoad;
              state_q <= StGap;
            end
          end else if (i_Abort) begin
            abort_q <= 1'b1;
          end
        end
        StGap: begin
          if (i_Abort) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (cnt_q <= CntOne) begin
            cnt_q   <= '0;
            state_q <= empty_q ? StIdle : StFetch;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_Char_Ready    = !full_q;
  assign o_Start         = start_q;
  assign o_Morse_Pattern = pattern_q;
  assign o_Morse_Length  = length_q;
  assign o_Busy          = (state_q != StIdle);
  assign o_Err           = err_q;

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Bench for morse_message_sequencer: table-driven encode vectors plus hand-written
// sequences for gaps, FIFO full, abort and asynchronous reset, checked via a scoreboard.
module tb_morse_message_sequencer;

  localparam int unsigned Unit      = 10;
  localparam int unsigned Depth     = 16;
  localparam int          DoneDelay = 5;

  logic       clk = 1'b0;
  logic       rst_n, char_valid, abort, done_man, auto_done, done_auto;
  logic [7:0] char_in;
  logic       char_ready, start, busy, err, done;
  logic [4:0] pattern;
  logic [2:0] length;

  assign done = auto_done ? done_auto : done_man;

  morse_message_sequencer #(
    .UNIT_CYCLES   (Unit),
    .DEPTH         (Depth),
    .CHAR_GAP_UNITS(3),
    .WORD_GAP_UNITS(7)
  ) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_Char_Valid   (char_valid),
    .i_Char         (char_in),
    .o_Char_Ready   (char_ready),
    .i_Abort        (abort),
    .o_Start        (start),
    .o_Morse_Pattern(pattern),
    .o_Morse_Length (length),
    .i_Done         (done),
    .o_Busy         (busy),
    .o_Err          (err)
  );

  typedef struct {logic [7:0] ch; logic ok; logic [4:0] pat; logic [2:0] len;} vec_t;
  typedef struct {logic [4:0] pat; logic [2:0] len;} exp_t;
  typedef struct {logic [4:0] pat; logic [2:0] len; int gap; int cyc;} obs_t;

  vec_t vecs [12];
  exp_t sb_q [$];
  obs_t obs_q [$];
  obs_t mon_o;

  int checks = 0, errors = 0;
  int cyc = 0, rise_cyc = 0, start_cnt = 0, err_cnt = 0, last_wcyc = 0;
  int dly = 0, hold = 0;

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  initial begin
    #500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  // Observes o_Start/o_Err and plays Morse_to_Signal: i_Done rises DoneDelay cycles after o_Start.
  initial begin
    done_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dly = 0;
        hold = 0;
        done_auto = 1'b0;
      end else begin
        if (start) begin
          mon_o.pat = pattern;
          mon_o.len = length;
          mon_o.gap = cyc - rise_cyc;
          mon_o.cyc = cyc;
          obs_q.push_back(mon_o);
          start_cnt++;
          dly = DoneDelay;
        end else if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            done_auto = 1'b1;
            rise_cyc = cyc;
            hold = 3;
          end
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) done_auto = 1'b0;
        end
        if (err) err_cnt++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  task automatic expect_char(input logic [4:0] p, input logic [2:0] l);
    exp_t e;
    e.pat = p;
    e.len = l;
    sb_q.push_back(e);
  endtask

  task automatic put(input logic [7:0] ch);
    int t = 0;
    while (!char_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    char_valid = 1'b1;
    char_in = ch;
    last_wcyc = cyc + 1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int t = 0;
    while (start_cnt < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_start_count"}, start_cnt, n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t = 0;
    @(negedge clk);
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic drain(input string tag);
    obs_t o;
    exp_t e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_start: actual pattern=%b length=%0d required=no start",
                 tag, o.pat, o.len);
      end else begin
        e = sb_q.pop_front();
        chk({tag, "_pattern"}, int'(o.pat), int'(e.pat));
        chk({tag, "_length"}, int'(o.len), int'(e.len));
      end
    end
    chk({tag, "_pending"}, sb_q.size(), 0);
  endtask

  initial begin
    int sc, ec, t0;
    vecs[0]  = '{"F", 1'b1, 5'b00100, 3'd4};
    vecs[1]  = '{"#", 1'b0, 5'b00000, 3'd0};
    vecs[2]  = '{"q", 1'b1, 5'b01011, 3'd4};
    vecs[3]  = '{"A", 1'b1, 5'b00010, 3'd2};
    vecs[4]  = '{"0", 1'b1, 5'b11111, 3'd5};
    vecs[5]  = '{"5", 1'b1, 5'b00000, 3'd5};
    vecs[6]  = '{"9", 1'b1, 5'b01111, 3'd5};
    vecs[7]  = '{"1", 1'b1, 5'b11110, 3'd5};
    vecs[8]  = '{"z", 1'b1, 5'b00011, 3'd4};
    vecs[9]  = '{"K", 1'b1, 5'b00101, 3'd3};
    vecs[10] = '{"!", 1'b0, 5'b00000, 3'd0};
    vecs[11] = '{"Y", 1'b1, 5'b01101, 3'd4};

    rst_n = 1'b0; char_valid = 1'b0; char_in = '0; abort = 1'b0;
    done_man = 1'b0; auto_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_start", int'(start), 0);
    chk("reset_pattern", int'(pattern), 0);
    chk("reset_length", int'(length), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_ready", int'(char_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // SOS: latency, char gaps, return to idle
    sc = start_cnt;
    expect_char(5'b00000, 3'd3); expect_char(5'b00111, 3'd3); expect_char(5'b00000, 3'd3);
    put("S"); t0 = last_wcyc; put("O"); put("S");
    wait_starts(sc + 3, 400, "sos");
    chk("sos_first_latency", obs_q[0].cyc - t0, 2);
    chk("sos_gap_1", obs_q[1].gap, 32);
    chk("sos_gap_2", obs_q[2].gap, 32);
    wait_idle(200, "sos");
    chk("sos_busy_fall", cyc - rise_cyc, 31);
    drain("sos");

    // "E E": word gap
    sc = start_cnt;
    expect_char(5'b00000, 3'd1); expect_char(5'b00000, 3'd1);
    put("E"); put(" "); put("E");
    wait_starts(sc + 2, 400, "ee");
    chk("ee_word_gap", obs_q[1].gap, 72);
    wait_idle(200, "ee");
    drain("ee");

    // Encode table, including unsupported characters
    sc = start_cnt; ec = err_cnt; t0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].ok) begin
        expect_char(vecs[i].pat, vecs[i].len);
        t0++;
      end
      put(vecs[i].ch);
    end
    wait_starts(sc + t0, 2000, "table");
    wait_idle(200, "table");
    chk("table_err_pulses", err_cnt - ec, 2);
    drain("table");

    // FIFO full while held in WAIT_DONE
    auto_done = 1'b0; done_man = 1'b0;
    sc = start_cnt;
    expect_char(5'b00000, 3'd1);
    put("E");
    wait_starts(sc + 1, 50, "full_hold");
    for (int i = 0; i < 17; i++) begin
      if (i == 15) chk("full_ready_at_15", int'(char_ready), 1);
      if (i == 16) chk("full_ready_at_16", int'(char_ready), 0);
      char_valid = 1'b1;
      char_in = (i == 16) ? 8'h54 : 8'h45;
      @(negedge clk);
    end
    char_valid = 1'b0;
    for (int i = 0; i < 16; i++) expect_char(5'b00000, 3'd1);
    chk("full_ready_still_low", int'(char_ready), 0);
    done_man = 1'b1; t0 = cyc;
    repeat (2) @(negedge clk);
    done_man = 1'b0;
    while (!char_ready && cyc - t0 < 100) @(negedge clk);
    chk("full_ready_after_pop", cyc - t0, 32);
    auto_done = 1'b1;
    wait_starts(sc + 17, 1500, "full");
    wait_idle(200, "full");
    drain("full");

    // Abort during WAIT_DONE with five characters queued
    auto_done = 1'b0; done_man = 1'b0;
    sc = start_cnt; ec = err_cnt;
    expect_char(5'b00010, 3'd2);
    put("A");
    wait_starts(sc + 1, 50, "abort_a");
    put("B"); put("C"); put("#"); put("D"); put("E");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    done_man = 1'b1;
    chk("abort_busy_before_done", int'(busy), 1);
    @(negedge clk);
    chk("abort_busy_fall", int'(busy), 0);
    @(negedge clk);
    done_man = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);
    chk("abort_ready", int'(char_ready), 1);
    chk("abort_no_more_starts", start_cnt - sc, 1);
    chk("abort_no_err", err_cnt - ec, 0);
    drain("abort");
    auto_done = 1'b1;

    // Asynchronous reset in the middle of a gap
    sc = start_cnt;
    expect_char(5'b00000, 3'd1);
    put("E");
    wait_starts(sc + 1, 50, "rst_e");
    repeat (20) @(negedge clk);
    chk("rst_busy_in_gap", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_start", int'(start), 0);
    chk("rst_async_pattern", int'(pattern), 0);
    chk("rst_async_length", int'(length), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_err", int'(err), 0);
    chk("rst_async_ready", int'(char_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drain("rst_pre");
    sc = start_cnt;
    expect_char(5'b00001, 3'd1);
    put("T"); t0 = last_wcyc;
    wait_starts(sc + 1, 50, "rst_t");
    chk("rst_t_latency", obs_q[0].cyc - t0, 2);
    wait_idle(200, "rst_t");
    drain("rst_t");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
